// File: rtl/ram_bus_master.sv
// Initiator for a 4-bit x 4096 asynchronous RAM chip bus: SETUP/ACCESS/HOLD beats,
// 1..16-beat incrementing bursts, and ownership of the shared data bus tri-state.
module ram_bus_master #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 4,
   parameter int unsigned ACC_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [3:0]        i_len,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_wd_ack,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_cs,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_dir,
   inout  wire  [DATA_W-1:0] io_data
);

   typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StTurn} state_e;

   localparam logic [3:0] AccLast = 4'(ACC_CYC - 1);

   state_e            r_state, w_state_next;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_len;
   logic [3:0]        r_cnt;
   logic [3:0]        r_acc;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              w_drv;
   logic              w_last_acc;
   logic              w_last_beat;

   assign w_last_acc  = (r_acc == AccLast);
   assign w_last_beat = (r_cnt == r_len);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      o_cs         = 1'b0;
      o_we         = 1'b0;
      w_drv        = 1'b0;
      o_wd_ack     = 1'b0;
      o_rvalid     = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_req) w_state_next = StSetup;
         end
         StSetup: begin
            o_we         = r_wr;
            w_drv        = r_wr;
            o_wd_ack     = r_wr;
            o_busy       = 1'b1;
            w_state_next = StAccess;
         end
         StAccess: begin
            o_cs   = 1'b1;
            o_we   = r_wr;
            w_drv  = r_wr;
            o_busy = 1'b1;
            if (w_last_acc) w_state_next = StHold;
         end
         StHold: begin
            // we and data stay put so the RAM sees a clean cs falling edge
            o_we         = r_wr;
            w_drv        = r_wr;
            o_rvalid     = ~r_wr;
            o_busy       = 1'b1;
            w_state_next = w_last_beat ? StTurn : StSetup;
         end
         StTurn: begin
            o_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_req) begin
                  r_wr   <= i_wr;
                  r_addr <= i_addr;
                  r_len  <= i_len;
                  r_cnt  <= '0;
               end
            end
            StSetup: begin
               r_acc <= '0;
               if (r_wr) r_wdata <= i_wdata;
            end
            StAccess: begin
               r_acc <= r_acc + 4'd1;
               // RAM output has settled by the last ACCESS cycle
               if (w_last_acc && !r_wr) r_rdata <= io_data;
            end
            StHold: begin
               if (!w_last_beat) begin
                  r_addr <= r_addr + ADDR_W'(1);
                  r_cnt  <= r_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dir   = r_addr;
   assign o_rdata = r_rdata;
   assign io_data = w_drv ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: RAM model on the bus, reference memory, bus-rule monitor,
// directed scenarios plus randomized bursts.
module tb_ram_bus_master;

   localparam int         ACC   = 2;
   localparam logic [3:0] FLOAT = 4'hF;  // value the pulled-up bus reads when nobody drives

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, wr;
   logic [11:0] addr;
   logic [3:0]  len;
   logic [3:0]  wdata;
   logic        wd_ack, rvalid, busy, done, cs, we;
   logic [3:0]  rdata;
   logic [11:0] dir;
   wire  [3:0]  data;

   always #5 clk = ~clk;

   ram_bus_master #(
      .ADDR_W (12),
      .DATA_W (4),
      .ACC_CYC(ACC)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_wr    (wr),
      .i_addr  (addr),
      .i_len   (len),
      .i_wdata (wdata),
      .o_wd_ack(wd_ack),
      .o_rdata (rdata),
      .o_rvalid(rvalid),
      .o_busy  (busy),
      .o_done  (done),
      .o_cs    (cs),
      .o_we    (we),
      .o_dir   (dir),
      .io_data (data)
   );

   pullup pu0 (data[0]);
   pullup pu1 (data[1]);
   pullup pu2 (data[2]);
   pullup pu3 (data[3]);

   // RAM chip model; unwritten cells return a fixed address hash
   logic [3:0]  ram_mem  [4096];
   bit          ram_flag [4096];
   logic [3:0]  ram_rd;
   logic        pl_en;
   logic [11:0] pl_addr;
   logic [3:0]  pl_data;
   wire         ram_drv = cs && !we;

   function automatic logic [3:0] init_val(input logic [11:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h6;
   endfunction

   always_comb ram_rd = ram_flag[dir] ? ram_mem[dir] : init_val(dir);
   assign data = ram_drv ? ram_rd : 4'bzzzz;

   always @(posedge clk) begin
      if (pl_en) begin
         ram_mem[pl_addr]  <= pl_data;
         ram_flag[pl_addr] <= 1'b1;
      end else if (cs && we) begin
         ram_mem[dir]  <= data;
         ram_flag[dir] <= 1'b1;
      end
   end

   function automatic logic [3:0] ram_val(input logic [11:0] a);
      return ram_flag[a] ? ram_mem[a] : init_val(a);
   endfunction

   // Bus monitor
   int          viol     = 0;
   int          done_cnt = 0;
   bit          in_read  = 1'b0;
   logic        p_cs     = 1'b0;
   logic        p_we     = 1'b0;
   logic [11:0] p_dir    = '0;

   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (rst_n)
         viol <= viol + int'(p_cs && (dir !== p_dir || we !== p_we))
                      + int'(ram_drv && data !== ram_rd)
                      + int'(in_read && !ram_drv && data !== FLOAT);
      p_cs  <= cs && rst_n;
      p_we  <= we;
      p_dir <= dir;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [3:0] ref_mem [4096];
   logic [3:0] wbuf    [16];
   int         n_acc = 0;

   task automatic run_txn(input logic t_wr, input logic [11:0] a, input logic [3:0] l,
                          input bit hold_req);
      int         cyc     = 0;
      int         wi      = 0;
      int         ri      = 0;
      int         beats   = 0;
      int         bad     = 0;
      int         cs_cyc  = 0;
      int         mism    = 0;
      int         exp_end = (int'(l) + 1) * (ACC + 2) + 1;
      bit         got_done = 1'b0;
      logic       prev_cs  = 1'b0;
      logic [11:0] ad;
      logic [3:0] exp_rd [16];
      for (int k = 0; k < 16; k++) begin
         ad        = a + 12'(k);
         exp_rd[k] = ref_mem[ad];
      end
      @(negedge clk);
      in_read = !t_wr;
      req     = 1'b1;
      wr      = t_wr;
      addr    = a;
      len     = l;
      wdata   = wbuf[0];
      n_acc++;
      while (!got_done && cyc < exp_end + 20) begin
         @(negedge clk);
         cyc++;
         if (hold_req) begin
            wr   = 1'($urandom);
            addr = 12'($urandom);
            len  = 4'($urandom);
         end else begin
            req = 1'b0;
         end
         wdata = (wi < 16) ? wbuf[wi] : 4'h0;
         if (busy !== (cyc < exp_end)) bad++;
         if (prev_cs && !cs) beats++;
         if (cs) begin
            cs_cyc++;
            if (dir !== 12'(a + 12'(beats))) bad++;
            if (t_wr && beats < 16 && data !== wbuf[beats]) bad++;
         end
         prev_cs = cs;
         if (wd_ack) wi++;
         if (rvalid) begin
            if (ri < 16) check("rdata", rdata, exp_rd[ri]);
            ri++;
         end
         if (done) begin
            got_done = 1'b1;
            check("done_cycle", cyc, exp_end);
            check("turn_release", data, FLOAT);
         end
      end
      if (hold_req) begin
         // req stayed high across TURN's closing edge; it must not start a burst
         @(negedge clk);
         req = 1'b0;
         check("turn_req_ignored", busy, 1'b0);
      end
      req     = 1'b0;
      in_read = 1'b0;
      check("done_seen", got_done, 1'b1);
      check("busy_dir_data", bad, 0);
      check("cs_cycles", cs_cyc, (int'(l) + 1) * ACC);
      if (t_wr) begin
         check("wd_acks", wi, int'(l) + 1);
         for (int k = 0; k <= int'(l); k++) begin
            ad          = a + 12'(k);
            ref_mem[ad] = wbuf[k];
         end
         for (int k = 0; k <= int'(l); k++) begin
            ad = a + 12'(k);
            if (ram_val(ad) !== ref_mem[ad]) mism++;
         end
         check("mem_write", mism, 0);
      end else begin
         check("rvalids", ri, int'(l) + 1);
      end
   endtask

   initial begin
      logic        rw;
      logic [11:0] ra;
      logic [3:0]  rl;
      bit          hr;
      int          dc;
      rst_n   = 1'b0;
      req     = 1'b0;
      wr      = 1'b0;
      addr    = '0;
      len     = '0;
      wdata   = '0;
      pl_en   = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));

      repeat (2) @(negedge clk);
      check("rst_cs", cs, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_dir", dir, 12'h000);
      check("rst_busy", busy, 1'b0);
      check("rst_flags", {done, rvalid, wd_ack}, 3'b000);
      check("rst_rdata", rdata, 4'h0);
      check("rst_data", data, FLOAT);
      rst_n = 1'b1;

      // Single write, then preloaded single read
      wbuf[0] = 4'hA;
      run_txn(1'b1, 12'h123, 4'd0, 1'b0);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 12'h123;
      pl_data = 4'h5;
      @(negedge clk);
      pl_en            = 1'b0;
      ref_mem[12'h123] = 4'h5;
      run_txn(1'b0, 12'h123, 4'd0, 1'b0);

      // Wrapping burst write and back-to-back read-back
      wbuf[0] = 4'h1;
      wbuf[1] = 4'h2;
      wbuf[2] = 4'h3;
      wbuf[3] = 4'h4;
      run_txn(1'b1, 12'hFFE, 4'd3, 1'b0);
      run_txn(1'b0, 12'hFFE, 4'd3, 1'b0);

      // req held high through a burst and its TURN
      for (int k = 0; k < 16; k++) wbuf[k] = 4'($urandom);
      run_txn(1'b1, 12'h040, 4'd2, 1'b1);
      run_txn(1'b0, 12'h040, 4'd2, 1'b1);

      for (int t = 0; t < 24; t++) begin
         rw = 1'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? 12'hFFF - 12'($urandom_range(0, 8))
                                          : 12'($urandom);
         rl = 4'($urandom);
         hr = ($urandom_range(0, 4) == 0);
         for (int k = 0; k < 16; k++) wbuf[k] = 4'($urandom);
         run_txn(rw, ra, rl, hr);
      end

      // Asynchronous reset in the middle of a write ACCESS
      @(negedge clk);
      req   = 1'b1;
      wr    = 1'b1;
      addr  = 12'h200;
      len   = 4'd5;
      wdata = 4'h7;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("pre_rst_cs", cs, 1'b1);
      dc = done_cnt;
      #1 rst_n = 1'b0;
      #1;
      check("arst_cs", cs, 1'b0);
      check("arst_we", we, 1'b0);
      check("arst_data", data, FLOAT);
      check("arst_busy", busy, 1'b0);
      check("arst_dir", dir, 12'h000);
      check("arst_rdata", rdata, 4'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("no_done_after_rst", done_cnt, dc);
      check("idle_after_rst", busy, 1'b0);
      check("done_per_req", done_cnt, n_acc);
      check("bus_rules", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
